// File: rtl/nn_loader_pkg.sv
// Shared definitions for the neural-network weight loaders: FSM encoding and
// the supported memory read-latency range.
package nn_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } loader_state_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/weight_rd_pipe.sv
// Tracks outstanding memory reads: carries a valid bit and slot index for
// RD_LAT cycles so each returning word lands in the slot it was issued for.
module weight_rd_pipe
  import nn_loader_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("weight_rd_pipe: RD_LAT out of supported range");
  end

  logic [RD_LAT-1:0] vld_q;
  logic [IDX_W-1:0]  idx_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid & ~flush;
      idx_q[0] <= in_idx;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1] & ~flush;
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/weight_loader_param.sv
// Streams IN_SIZE*OUT_SIZE weights from an external read-latency memory into
// a flat register bank, with abort and a done pulse on completion.
module weight_loader_param
  import nn_loader_pkg::*;
#(
  parameter int unsigned IN_SIZE    = 64,
  parameter int unsigned OUT_SIZE   = 8,
  parameter int unsigned W          = 8,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  output logic                           mem_en,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [W-1:0]                   mem_rdata,
  output logic                           busy,
  output logic                           done,
  output logic                           valid,
  output logic [IN_SIZE*OUT_SIZE*W-1:0]  data_out
);

  localparam int unsigned TOTAL = IN_SIZE * OUT_SIZE;
  localparam int unsigned IDX_W = $clog2(TOTAL + 1);

  loader_state_t             state, next_state;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [IDX_W-1:0]          issue_cnt;
  logic                      valid_q;
  logic [TOTAL*W-1:0]        data_q;
  logic                      flush;
  logic                      pipe_valid;
  logic [IDX_W-1:0]          pipe_idx;
  logic                      last_issue;
  logic                      last_capture;

  assign flush        = abort && (state != S_IDLE);
  assign last_issue   = (issue_cnt == IDX_W'(TOTAL - 1));
  assign last_capture = pipe_valid && (pipe_idx == IDX_W'(TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (start) next_state = S_ISSUE;
      S_ISSUE:  if (abort) next_state = S_IDLE;
                else if (last_issue) next_state = S_DRAIN;
      S_DRAIN:  if (abort) next_state = S_IDLE;
                else if (last_capture) next_state = S_FINISH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = base_q + ADDR_WIDTH'(issue_cnt);
        busy     = 1'b1;
      end
      S_DRAIN:  busy = 1'b1;
      S_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // valid rises together with the final capture so it is already high in FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      issue_cnt <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        base_q    <= base_addr;
        issue_cnt <= '0;
        valid_q   <= 1'b0;
      end else if (flush) begin
        valid_q   <= 1'b0;
      end else begin
        if (state == S_ISSUE) issue_cnt <= issue_cnt + 1'b1;
        if (state == S_DRAIN && last_capture) valid_q <= 1'b1;
      end
      for (int unsigned k = 0; k < TOTAL; k++) begin
        if (pipe_valid && !flush && pipe_idx == IDX_W'(k))
          data_q[k*W +: W] <= mem_rdata;
      end
    end
  end

  weight_rd_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (mem_en),
    .in_idx    (issue_cnt),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  assign valid    = valid_q;
  assign data_out = data_q;

endmodule
